stage_ack_responder: RTL and testbench
======================================

# stage_ack_responder

Clocked responder for the request side of `asyn_controller`. It accepts the five four-phase stage requests (`req1`, `req2_1`, `req2_2`, `req3`, `req4`) and returns one acknowledge per request after a stage-specific latency. The memory-stage latency is selected from the RISC-V opcode. The block sits between the asynchronous controller and the synchronous datapath model, and also flags four-phase protocol violations.

## Interface
- `FETCH_LAT`, 2, cycles from seen `req1` to `ack1`; legal range 1..15
- `DEC_LAT`, 1, latency for `req2_1` and for `req2_2`; legal range 1..15
- `EXEC_LAT`, 3, latency for `req3`; legal range 1..15
- `MEM_LAT`, 4, latency for `req4` when the opcode is LOAD or STORE; legal range 1..15
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low; clears all state
- `opcode` input 7: instruction opcode, sampled only when the `req4` channel leaves IDLE
- `req1`, `req2_1`, `req2_2`, `req3`, `req4` input 1 each: four-phase requests, asynchronous to `clk`
- `err_clr` input 1: synchronous clear of `err`
- `ack1`, `ack2_1`, `ack2_2`, `ack3`, `ack4` output 1 each: registered acknowledges
- `busy` output 1: registered; high when any channel is not IDLE
- `err` output 5: sticky protocol-violation flags; bit order [4]=req4 … [0]=req1
- `done_cnt` output 16: count of completed handshakes, wraps at 16 bits

## Operation
- Five independent channels. Each runs FSM IDLE → WAIT → ACK → IDLE on its qualified request `rq`.
- IDLE, `rq`=1: load counter with LAT-1 and go to WAIT.
- WAIT, `rq`=0: protocol violation. Set the channel's `err` bit and return to IDLE; no ack is issued.
- WAIT, counter≠0: decrement.
- WAIT, counter=0: go to ACK with ack=1.
- ACK: hold ack=1 until `rq`=0; then go to IDLE with ack=0 and increment `done_cnt` by one.
- Channel 4 latency is MEM_LAT if the captured opcode is 7'b0000011 (LOAD) or 7'b0100011 (STORE); otherwise it is 1. The opcode is captured on the IDLE→WAIT edge. Later opcode changes do not affect the handshake in flight.
- Simultaneous completions in one cycle: `done_cnt` adds the number of channels completing, 0..5, modulo 2^16.
- `err_clr` clears all `err` bits. If a violation occurs in the same cycle, the new violation's bit is still set (set wins).
- `busy` is the registered OR of (state≠IDLE) over the five channels.

## Timing
- Reset value of every output is 0, and every FSM is IDLE. Reset is asynchronous, so assertion mid-handshake drops all acks immediately.
- Let e0 be the first edge at which a channel in IDLE sees `rq`=1. The ack is high after edge e0+LAT.
- Example: LAT=1 means ack is high after e0+1.
- The ack falls on the first edge at which that channel's `rq` is seen 0 while in ACK. IDLE can accept a new `rq` on the next edge.
- Minimum handshake is LAT+2 edges of `rq` observation, plus synchronizer delay when enabled.
- Each channel's counter is 4 bits wide.

## Configuration
- `ACK_SYNC_EN` defined: each req passes through a 2-flop synchronizer, reset to 0, before the FSM. `rq` lags the pin by 2 edges, so end-to-end req→ack is LAT+2 edges.
- `ACK_SYNC_EN` undefined: `rq` is the raw pin. Use this only when the requests are already synchronous to `clk` (bench and FPGA bring-up); req→ack is LAT edges.

## Structure
- Package `stage_ack_pkg` holds:
  - enum `ack_state_t {IDLE, WAIT, ACK}`
  - `OP_LOAD` = 7'b0000011 and `OP_STORE` = 7'b0100011
  - channel index constants `CH_FETCH`=0, `CH_DEC1`=1, `CH_DEC2`=2, `CH_EXEC`=3, `CH_MEM`=4
- Sub-module `ack_channel` contains one synchronizer (under the macro), the FSM, the counter and the violation pulse. It is instantiated five times.
- The top level contains the opcode latency select, `err` register, `busy` and the `done_cnt` adder.

## Test plan
- Defaults, no macro. Raise `req3` at e0 → `ack3` rises after e0+3. Drop `req3` → `ack3` falls the next edge and `done_cnt`=1.
- `opcode`=7'b0000011 and raise `req4`; change `opcode` to 7'b0110011 during WAIT → ack after 4 edges. Repeat with 7'b0110011 at capture → ack after 1 edge.
- Raise all five reqs on the same edge, drop them together after all acks are high → each ack obeys its own latency and `done_cnt` jumps by 5 in one cycle.
- Raise `req1`, drop it 1 edge later (before the ack) → `err`=5'b00001, no `ack1`. Then pulse `err_clr` → `err`=0.
- Pull `reset` low while `ack2_1` is high and `busy`=1 → all outputs are 0 immediately. After release, a new `req2_1` completes normally.
- With `ACK_SYNC_EN` → same stimulus as the first scenario yields `ack3` after e0+5 relative to the pin.

Source files
------------

// File: rtl/stage_ack_pkg.sv
// Shared types and constants for the stage acknowledge responder.
// The optional ACK_SYNC_EN macro is consumed by ack_channel. This package does not use it.
package stage_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ack_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int CH_FETCH = 0;
  localparam int CH_DEC1  = 1;
  localparam int CH_DEC2  = 2;
  localparam int CH_EXEC  = 3;
  localparam int CH_MEM   = 4;

  // Returns 1 when the memory stage needs its long latency.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Counts how many channels completed a handshake this cycle (0..5).
  function automatic logic [2:0] done_sum(input logic [4:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 5; i++) s = s + 3'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/ack_channel.sv
// One four-phase acknowledge channel: optional input synchronizer, FSM, latency down-counter.
// ACK_SYNC_EN defined: req passes a 2-flop synchronizer before the FSM.
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | counting down the stage latency, request must stay high
// ACK   | ack driven high until the request drops
module ack_channel
  import stage_ack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] lat,
  output logic       ack,
  output logic       active_nxt,
  output logic       done,
  output logic       viol
);

  logic       rq;
  ack_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ack_nxt;

`ifdef ACK_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer for the asynchronous request pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b00;
    else        sync <= {sync[0], req};
  end

  assign rq = sync[1];
`else
  assign rq = req;
`endif

  // Next-state, counter and pulse decode; a dropped request in WAIT takes priority over expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = ack;
    done      = 1'b0;
    viol      = 1'b0;
    case (state)
      IDLE: begin
        if (rq) begin
          cnt_nxt   = lat - 4'd1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!rq) begin
          viol      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = ACK;
          ack_nxt   = 1'b1;
        end
      end
      ACK: begin
        if (!rq) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b0;
          done      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ack_nxt   = 1'b0;
      end
    endcase
  end

  assign active_nxt = (state_nxt != IDLE);

  // State, counter and ack registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
    end
  end

endmodule

// File: rtl/stage_ack_responder.sv
// Clocked acknowledge responder for the five asyn_controller stage requests.
// Optional macro ACK_SYNC_EN adds a 2-flop request synchronizer in every channel.
module stage_ack_responder
  import stage_ack_pkg::*;
#(
  parameter int FETCH_LAT = 2,
  parameter int DEC_LAT   = 1,
  parameter int EXEC_LAT  = 3,
  parameter int MEM_LAT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        req1,
  input  logic        req2_1,
  input  logic        req2_2,
  input  logic        req3,
  input  logic        req4,
  input  logic        err_clr,
  output logic        ack1,
  output logic        ack2_1,
  output logic        ack2_2,
  output logic        ack3,
  output logic        ack4,
  output logic        busy,
  output logic [4:0]  err,
  output logic [15:0] done_cnt
);

  logic [4:0] req_vec, ack_vec, act_vec, done_vec, viol_vec;
  logic [3:0] lat_vec [5];

  assign req_vec = {req4, req3, req2_2, req2_1, req1};
  assign {ack4, ack3, ack2_2, ack2_1, ack1} = ack_vec;

  // Per-channel latency; the memory channel only latches this on its IDLE->WAIT edge.
  always_comb begin
    lat_vec[CH_FETCH] = 4'(FETCH_LAT);
    lat_vec[CH_DEC1]  = 4'(DEC_LAT);
    lat_vec[CH_DEC2]  = 4'(DEC_LAT);
    lat_vec[CH_EXEC]  = 4'(EXEC_LAT);
    lat_vec[CH_MEM]   = is_mem_op(opcode) ? 4'(MEM_LAT) : 4'd1;
  end

  for (genvar i = 0; i < 5; i++) begin : g_ch
    ack_channel u_ch (
      .clk        (clk),
      .reset      (reset),
      .req        (req_vec[i]),
      .lat        (lat_vec[i]),
      .ack        (ack_vec[i]),
      .active_nxt (act_vec[i]),
      .done       (done_vec[i]),
      .viol       (viol_vec[i])
    );
  end

  // Sticky error flags, busy and completion counter; a new violation wins over err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 5'd0;
      busy     <= 1'b0;
      done_cnt <= 16'd0;
    end else begin
      err      <= (err_clr ? 5'd0 : err) | viol_vec;
      busy     <= |act_vec;
      done_cnt <= done_cnt + {13'd0, done_sum(done_vec)};
    end
  end

endmodule

// File: tb/tb_stage_ack_responder.sv
// Directed self-checking bench for stage_ack_responder with a scoreboard of expected values.
// Adapts expected latencies when ACK_SYNC_EN is defined.
module tb_stage_ack_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        req1 = 1'b0, req2_1 = 1'b0, req2_2 = 1'b0, req3 = 1'b0, req4 = 1'b0;
  logic        err_clr = 1'b0;
  logic        ack1, ack2_1, ack2_2, ack3, ack4;
  logic        busy;
  logic [4:0]  err;
  logic [15:0] done_cnt;

`ifdef ACK_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  localparam int LAT [5] = '{2, 1, 1, 3, 4};

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  stage_ack_responder #(
    .FETCH_LAT(2), .DEC_LAT(1), .EXEC_LAT(3), .MEM_LAT(4)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .req1(req1), .req2_1(req2_1), .req2_2(req2_2), .req3(req3), .req4(req4),
    .err_clr(err_clr),
    .ack1(ack1), .ack2_1(ack2_1), .ack2_2(ack2_2), .ack3(ack3), .ack4(ack4),
    .busy(busy), .err(err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] acks();
    return {ack4, ack3, ack2_2, ack2_1, ack1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic v);
    case (ch)
      0: req1   = v;
      1: req2_1 = v;
      2: req2_2 = v;
      3: req3   = v;
      default: req4 = v;
    endcase
  endtask

  // Pops the next expected value and compares it with the observation.
  task automatic check(input string tag, input int obs);
    int expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %0d", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
    end
  endtask

  // Ticks from `start` until channel ch's ack reaches level; returns edge count, -1 on timeout.
  task automatic wait_ack(input int ch, input logic level, input int start, output int n);
    logic [4:0] a;
    n = -1;
    for (int c = start + 1; c <= 40; c++) begin
      tick();
      a = acks();
      if (a[ch] == level) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int first [5];
    logic [4:0] a;
    logic seen;

    // Reset state
    repeat (2) tick();
    exp_q.push_back(0); check("reset_acks", int'(acks()));
    exp_q.push_back(0); check("reset_busy", int'(busy));
    exp_q.push_back(0); check("reset_err", int'(err));
    exp_q.push_back(0); check("reset_done", int'(done_cnt));
    reset = 1'b1;
    tick();

    // Execute channel: latency 3, ack falls one edge after req drops
    exp_q.push_back(3 + SYNC);
    req3 = 1'b1;
    wait_ack(3, 1'b1, 0, n);
    check("exec_lat", n - 1);
    exp_q.push_back(1); check("exec_busy", int'(busy));
    exp_q.push_back(1 + SYNC);
    req3 = 1'b0;
    wait_ack(3, 1'b0, 0, n);
    check("exec_fall", n);
    exp_q.push_back(0); check("exec_idle_busy", int'(busy));
    exp_q.push_back(1); check("exec_done", int'(done_cnt));

    // Memory channel: LOAD captured, opcode change in WAIT must not matter
    opcode = 7'b0000011;
    exp_q.push_back(4 + SYNC);
    req4 = 1'b1;
    repeat (SYNC + 2) tick();
    opcode = 7'b0110011;
    wait_ack(4, 1'b1, SYNC + 2, n);
    check("mem_load_lat", n - 1);
    exp_q.push_back(1 + SYNC);
    req4 = 1'b0;
    wait_ack(4, 1'b0, 0, n);
    check("mem_load_fall", n);
    exp_q.push_back(2); check("mem_load_done", int'(done_cnt));

    // Memory channel: non-memory opcode at capture gives latency 1
    exp_q.push_back(1 + SYNC);
    req4 = 1'b1;
    wait_ack(4, 1'b1, 0, n);
    check("mem_alu_lat", n - 1);
    exp_q.push_back(1 + SYNC);
    req4 = 1'b0;
    wait_ack(4, 1'b0, 0, n);
    check("mem_alu_fall", n);
    exp_q.push_back(3); check("mem_alu_done", int'(done_cnt));
    exp_q.push_back(0); check("no_err", int'(err));

    // All five channels together, STORE opcode
    opcode = 7'b0100011;
    for (int ch = 0; ch < 5; ch++) begin
      exp_q.push_back(LAT[ch] + SYNC);
      first[ch] = -1;
      set_req(ch, 1'b1);
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      a = acks();
      for (int ch = 0; ch < 5; ch++)
        if (a[ch] && first[ch] < 0) first[ch] = c;
      if (a == 5'b11111) break;
    end
    for (int ch = 0; ch < 5; ch++) check($sformatf("all_lat_ch%0d", ch), first[ch] - 1);
    exp_q.push_back(1 + SYNC);
    exp_q.push_back(8);
    for (int ch = 0; ch < 5; ch++) set_req(ch, 1'b0);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (acks() == 5'b00000) begin
        n = c;
        break;
      end
    end
    check("all_fall", n);
    check("all_done", int'(done_cnt));

    // Violation on req1 coinciding with err_clr: set wins, no ack1
    exp_q.push_back(1);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    repeat (SYNC) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("viol_err", int'(err));
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack1) seen = 1'b1;
    end
    exp_q.push_back(0); check("viol_no_ack1", int'(seen));
    exp_q.push_back(8); check("viol_done", int'(done_cnt));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_q.push_back(0); check("err_clr", int'(err));

    // Asynchronous reset mid-handshake
    exp_q.push_back(1 + SYNC);
    req2_1 = 1'b1;
    wait_ack(1, 1'b1, 0, n);
    check("dec1_lat", n - 1);
    exp_q.push_back(1); check("dec1_busy", int'(busy));
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(0); check("arst_acks", int'(acks()));
    exp_q.push_back(0); check("arst_busy", int'(busy));
    exp_q.push_back(0); check("arst_done", int'(done_cnt));
    req2_1 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_q.push_back(1 + SYNC);
    req2_1 = 1'b1;
    wait_ack(1, 1'b1, 0, n);
    check("post_rst_lat", n - 1);
    exp_q.push_back(1 + SYNC);
    req2_1 = 1'b0;
    wait_ack(1, 1'b0, 0, n);
    check("post_rst_fall", n);
    exp_q.push_back(1); check("post_rst_done", int'(done_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
